// File: rtl/fetch_unit.sv
// Instruction fetch front end: keeps the fetch PC, issues single-word I-cache reads
// and buffers {pc, inst} pairs for decode, with redirect flush and stale-fetch squash.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        cif_read,
  output logic [31:0] cif_addr,
  output logic        cif_done,
  input  logic        cif_ready,
  input  logic [31:0] cif_load,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        busy
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   req_addr_q;
  logic          stale_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic [31:0]   inst_mem_q [QUEUE_DEPTH];

  logic          push;
  logic          pop;
  logic          can_issue;
  logic          issue;
  logic [CW-1:0] reserved;

  assign cif_read   = (state_q == REQ);
  assign cif_done   = cif_read & cif_ready;
  assign busy       = cif_read;
  assign cif_addr   = req_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_mem_q[head_q];
  assign inst_pc    = pc_mem_q[head_q];

  // A word completing this cycle already holds a slot; a pop in the same cycle does not free one.
  assign reserved  = count_q + CW'(cif_done & ~stale_q);
  assign can_issue = ~halt & ~redirect & (reserved < CW'(QUEUE_DEPTH));
  assign issue     = can_issue & ((state_q == IDLE) | cif_done);

  // Redirect overrides both queue ports: the flushed queue is empty next cycle.
  assign push = cif_done & ~stale_q & ~redirect;
  assign pop  = inst_valid & inst_ready & ~redirect;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      stale_q    <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE:    if (issue) state_q <= REQ;
        REQ:     if (cif_done && !issue) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (issue) req_addr_q <= fetch_pc_q;

      if (redirect)   fetch_pc_q <= redirect_pc & ~32'd3;
      else if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;

      // The in-flight request can never be aborted, so its word is marked for discard instead.
      if (cif_done)                 stale_q <= 1'b0;
      else if (redirect && cif_read) stale_q <= 1'b1;

      if (push) begin
        pc_mem_q[tail_q]   <= req_addr_q;
        inst_mem_q[tail_q] <= cif_load;
      end

      if (redirect) begin
        count_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
        if (push && !pop)      count_q <= count_q + CW'(1);
        else if (pop && !push) count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural I-cache with adjustable latency and
// queues of expected request addresses and expected decode-side {pc, inst} pairs.
module tb_fetch_unit;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cif_read, cif_done, cif_ready;
  logic [31:0] cif_addr, cif_load;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect, halt, busy;
  logic [31:0] redirect_pc;

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          done_cnt = 0;
  logic [31:0] exp_req [$];
  logic [31:0] exp_out [$];

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .cif_read(cif_read), .cif_addr(cif_addr), .cif_done(cif_done),
    .cif_ready(cif_ready), .cif_load(cif_load),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_read"},  {31'd0, cif_read},   32'd0);
    check_eq({tag, "_done"},  {31'd0, cif_done},   32'd0);
    check_eq({tag, "_addr"},  cif_addr,            RPC);
    check_eq({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, "_inst"},  inst,                32'd0);
    check_eq({tag, "_pc"},    inst_pc,             32'd0);
    check_eq({tag, "_busy"},  {31'd0, busy},       32'd0);
  endtask

  // Cache: ready after lat idle cycles of a held request, data = addr ^ MASK.
  initial begin
    int cnt = 0;
    cif_ready = 1'b0;
    cif_load  = '0;
    forever begin
      @(negedge clk);
      if (nrst && cif_read) begin
        if (cnt >= lat) begin
          cif_ready = 1'b1;
          cif_load  = cif_addr ^ MASK;
          cnt = 0;
        end else begin
          cif_ready = 1'b0;
          cnt++;
        end
      end else begin
        cif_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor just before each rising edge: completed requests and consumed queue heads.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (nrst) begin
        if (cif_done) begin
          done_cnt++;
          if (exp_req.size() == 0) check_eq("req_unexpected", cif_addr, 32'hFFFF_FFFF);
          else check_eq("req_addr", cif_addr, exp_req.pop_front());
        end
        if (inst_valid && inst_ready && !redirect) begin
          if (exp_out.size() == 0) check_eq("out_unexpected", inst_pc, 32'hFFFF_FFFF);
          else begin
            logic [31:0] e;
            e = exp_out.pop_front();
            check_eq("out_pc", inst_pc, e);
            check_eq("out_inst", inst, e ^ MASK);
          end
        end
      end
    end
  end

  initial begin
    int d0;
    bit found;
    nrst = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    tick(2);
    check_reset_outputs("rst");

    // Sequential hit stream from RESET_PC, halted in REQ after 0x108
    exp_req.push_back(32'h100); exp_req.push_back(32'h104); exp_req.push_back(32'h108);
    exp_out.push_back(32'h100); exp_out.push_back(32'h104); exp_out.push_back(32'h108);
    nrst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("seq_read", {31'd0, cif_read}, 32'd1);
      check_eq("seq_addr", cif_addr, 32'h100 + 32'(((i - 1) / 2) * 4));
      if (i == 3) check_eq("seq_first_pc", inst_pc, 32'h100);
      if (i == 5) halt = 1'b1;
    end
    tick();
    check_eq("halt_stop", {31'd0, cif_read}, 32'd0);
    tick(4);
    check_eq("halt_stays", {31'd0, cif_read}, 32'd0);
    check_eq("seq_drained", 32'(exp_out.size()), 32'd0);
    exp_req.push_back(32'h10C); exp_out.push_back(32'h10C);
    halt = 1'b0;
    tick();
    tick();
    check_eq("resume_addr", cif_addr, 32'h10C);
    check_eq("resume_read", {31'd0, cif_read}, 32'd1);
    halt = 1'b1;
    tick(5);

    // Full queue with decode stalled
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_req.push_back(32'h110 + 32'(4 * i));
      exp_out.push_back(32'h110 + 32'(4 * i));
    end
    d0 = done_cnt;
    halt = 1'b0;
    tick(20);
    check_eq("full_done", 32'(done_cnt - d0), 32'd4);
    check_eq("full_read", {31'd0, cif_read}, 32'd0);
    check_eq("full_head", inst_pc, 32'h110);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_eq("pop_no_issue_yet", {31'd0, cif_read}, 32'd0);
    tick();
    check_eq("pop_issue_read", {31'd0, cif_read}, 32'd1);
    check_eq("pop_issue_addr", cif_addr, 32'h120);
    tick(10);
    check_eq("pop_one_more", 32'(done_cnt - d0), 32'd5);
    check_eq("pop_refull_read", {31'd0, cif_read}, 32'd0);
    halt = 1'b1;
    inst_ready = 1'b1;
    tick(8);
    check_eq("full_drained", 32'(exp_out.size()), 32'd0);
    check_eq("full_empty", {31'd0, inst_valid}, 32'd0);

    // Long miss at 0x200 with a redirect to 0x403 mid-miss
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; lat = 10; halt = 1'b0;
    exp_req.push_back(32'h200); exp_req.push_back(32'h400);
    exp_out.push_back(32'h400);
    tick();
    check_eq("miss_addr", cif_addr, 32'h200);
    tick(2);
    redirect = 1'b1; redirect_pc = 32'h403;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cif_read && cif_addr == 32'h400) begin
        found = 1'b1;
        halt = 1'b1;
      end else begin
        if (cif_read) check_eq("miss_hold", cif_addr, 32'h200);
        tick();
      end
    end
    check_eq("redir_reached", {31'd0, found}, 32'd1);
    tick(15);
    check_eq("redir_req_done", 32'(exp_req.size()), 32'd0);
    check_eq("redir_out_done", 32'(exp_out.size()), 32'd0);

    // Redirect coinciding with completion and pop on a non-empty queue
    lat = 1; inst_ready = 1'b0;
    exp_req.push_back(32'h404); exp_req.push_back(32'h408); exp_req.push_back(32'h800);
    exp_out.push_back(32'h800);
    halt = 1'b0;
    tick();
    check_eq("coinc_addr0", cif_addr, 32'h404);
    tick(2);
    check_eq("coinc_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("coinc_head", inst_pc, 32'h404);
    check_eq("coinc_addr1", cif_addr, 32'h408);
    tick();
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h800;
    tick();
    redirect = 1'b0;
    check_eq("coinc_flushed", {31'd0, inst_valid}, 32'd0);
    check_eq("coinc_no_issue", {31'd0, cif_read}, 32'd0);
    tick();
    check_eq("coinc_target", cif_addr, 32'h800);
    check_eq("coinc_target_rd", {31'd0, cif_read}, 32'd1);
    halt = 1'b1;
    tick(5);
    check_eq("coinc_out_done", 32'(exp_out.size()), 32'd0);

    // Address wrap at the top of the space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect = 1'b0; halt = 1'b0;
    exp_req.push_back(32'hFFFF_FFF8); exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_out.push_back(32'hFFFF_FFF8); exp_out.push_back(32'hFFFF_FFFC); exp_out.push_back(32'h0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("wrap_addr", cif_addr, 32'hFFFF_FFF8 + 32'(((i - 1) / 2) * 4));
      if (i == 5) halt = 1'b1;
    end
    tick(4);
    check_eq("wrap_out_done", 32'(exp_out.size()), 32'd0);

    // Asynchronous reset in the middle of a miss with a queued entry
    inst_ready = 1'b0;
    exp_req.push_back(32'h4);
    halt = 1'b0;
    tick();
    check_eq("ar_addr0", cif_addr, 32'h4);
    tick();
    #2 lat = 20;
    tick();
    check_eq("ar_valid", {31'd0, inst_valid}, 32'd1);
    check_eq("ar_head", inst_pc, 32'h4);
    check_eq("ar_inst", inst, 32'h4 ^ MASK);
    check_eq("ar_miss_addr", cif_addr, 32'h8);
    tick(2);
    #2 nrst = 1'b0;
    #1 check_reset_outputs("arst");
    check_eq("ar_req_done", 32'(exp_req.size()), 32'd0);
    check_eq("ar_out_done", 32'(exp_out.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
